// File: rtl/piano_pkg.sv
// piano_pkg: definitions shared by the piano front-end blocks.
//   NKEYS            number of key switches (the packed map assumes 8)
//   NOTE_UNASSIGNED  nibble value for a key that has no note yet
//   MAP_IDENTITY     key k -> note k, the power-up map
//   MAP_UNASSIGNED   working map at the start of a recording
//   rec_state_t      recorder FSM encoding
//   key_nibble_lsb   bit position of key k's nibble in a packed map
package piano_pkg;

  localparam int          NKEYS           = 8;
  localparam logic [3:0]  NOTE_UNASSIGNED = 4'hF;
  localparam logic [31:0] MAP_IDENTITY    = 32'h01234567;
  localparam logic [31:0] MAP_UNASSIGNED  = 32'hFFFFFFFF;

  typedef enum logic {
    IDLE   = 1'b0,
    RECORD = 1'b1
  } rec_state_t;

  // Key 0 lives in the top nibble, key 7 in the bottom one.
  function automatic int key_nibble_lsb(input int key);
    return (NKEYS - 1 - key) * 4;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions one raw switch.
//   clk    system clock
//   rst    asynchronous active-high reset
//   raw    raw switch level, asynchronous to clk
//   level  debounced level; follows raw 2 + DEBOUNCE_CYCLES clocks after
//          raw last changed
// The synchronised input must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive clocks before the level flips; any return
// to the accepted level restarts the count.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/key_map_recorder.sv
// key_map_recorder: debounces the key and setting switches and records a
// user key-to-note remapping.
//   clk, rst      system clock, asynchronous active-high reset
//   key_in[7:0]   raw key switches (bit k = key k), active-high
//   setting       raw setting switch, active-high
//   map_out       committed map, bits [31-4k:28-4k] = note of key k
//   recording     high while recording a new map
//   assign_pulse  one-cycle strobe per accepted assignment
//   assign_key    key of the latest assignment (held between strobes)
//   assign_note   note of the latest assignment (held between strobes)
//   done_pulse    one-cycle strobe when a new map is committed
//   abort_pulse   one-cycle strobe when recording is abandoned
// map_out only changes on a full commit or on reset, so the player never
// sees a partially recorded map.
module key_map_recorder #(
  parameter int NKEYS           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEYS-1:0]  key_in,
  input  logic              setting,
  output logic [4*NKEYS-1:0] map_out,
  output logic              recording,
  output logic              assign_pulse,
  output logic [2:0]        assign_key,
  output logic [2:0]        assign_note,
  output logic              done_pulse,
  output logic              abort_pulse
);

  import piano_pkg::*;

  localparam int HOLDOFF = DEBOUNCE_CYCLES + 3;
  localparam int HW      = $clog2(HOLDOFF + 1);

  // ---------------- input conditioning ----------------
  logic [NKEYS:0] raw_all;
  logic [NKEYS:0] level_all;
  logic [NKEYS:0] prev_reg;

  assign raw_all = {setting, key_in};

  generate
    for (genvar gi = 0; gi <= NKEYS; gi++) begin : g_db
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_all[gi]),
        .level(level_all[gi])
      );
    end
  endgenerate

  logic [NKEYS-1:0] key_rise;
  logic             setting_level;
  logic             setting_rise;

  // A setting switch held through reset debounces to 1 shortly after reset
  // and would look like a fresh press. Setting edges are therefore only
  // honoured once the debouncers have settled and setting has been seen low.
  logic [HW-1:0] holdoff_cnt_reg;
  logic          holdoff_done;
  logic          setting_armed_reg;

  assign holdoff_done  = (holdoff_cnt_reg == HW'(HOLDOFF));
  assign setting_level = level_all[NKEYS];
  assign key_rise      = level_all[NKEYS-1:0] & ~prev_reg[NKEYS-1:0];
  assign setting_rise  = setting_level & ~prev_reg[NKEYS] & setting_armed_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg          <= '0;
      holdoff_cnt_reg   <= '0;
      setting_armed_reg <= 1'b0;
    end else begin
      prev_reg <= level_all;
      if (!holdoff_done) begin
        holdoff_cnt_reg <= holdoff_cnt_reg + 1'b1;
      end
      if (holdoff_done && !setting_level) begin
        setting_armed_reg <= 1'b1;
      end
    end
  end

  // ---------------- recorder FSM ----------------
  rec_state_t         state_reg, state_next;
  logic [4*NKEYS-1:0] work_reg, work_next;
  logic [4*NKEYS-1:0] map_reg, map_next;
  logic [2:0]         next_note_reg, next_note_next;
  logic               assign_pulse_reg, assign_pulse_next;
  logic [2:0]         assign_key_reg, assign_key_next;
  logic [2:0]         assign_note_reg, assign_note_next;
  logic               done_pulse_reg, done_pulse_next;
  logic               abort_pulse_reg, abort_pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      work_reg         <= MAP_UNASSIGNED;
      map_reg          <= MAP_IDENTITY;
      next_note_reg    <= '0;
      assign_pulse_reg <= 1'b0;
      assign_key_reg   <= '0;
      assign_note_reg  <= '0;
      done_pulse_reg   <= 1'b0;
      abort_pulse_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      work_reg         <= work_next;
      map_reg          <= map_next;
      next_note_reg    <= next_note_next;
      assign_pulse_reg <= assign_pulse_next;
      assign_key_reg   <= assign_key_next;
      assign_note_reg  <= assign_note_next;
      done_pulse_reg   <= done_pulse_next;
      abort_pulse_reg  <= abort_pulse_next;
    end
  end

  always_comb begin
    logic       sel_valid;
    logic [2:0] sel_key;
    int         sel_pos;

    state_next        = state_reg;
    work_next         = work_reg;
    map_next          = map_reg;
    next_note_next    = next_note_reg;
    assign_pulse_next = 1'b0;
    assign_key_next   = assign_key_reg;
    assign_note_next  = assign_note_reg;
    done_pulse_next   = 1'b0;
    abort_pulse_next  = 1'b0;

    // Scan downwards so the lowest-index rising key wins; the others are
    // simply dropped.
    sel_valid = 1'b0;
    sel_key   = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (key_rise[k]) begin
        sel_valid = 1'b1;
        sel_key   = 3'(k);
      end
    end
    sel_pos = key_nibble_lsb(int'(sel_key));

    case (state_reg)
      IDLE: begin
        if (setting_rise) begin
          state_next     = RECORD;
          work_next      = MAP_UNASSIGNED;
          next_note_next = '0;
        end
      end
      RECORD: begin
        // Setting low takes priority over any key edge in the same cycle.
        if (!setting_level) begin
          state_next       = IDLE;
          abort_pulse_next = 1'b1;
        end else if (sel_valid &&
                     work_reg[sel_pos +: 4] == NOTE_UNASSIGNED) begin
          work_next[sel_pos +: 4] = {1'b0, next_note_reg};
          assign_pulse_next       = 1'b1;
          assign_key_next         = sel_key;
          assign_note_next        = next_note_reg;
          next_note_next          = next_note_reg + 3'd1;
          if (next_note_reg == 3'd7) begin
            state_next      = IDLE;
            map_next        = work_next;
            done_pulse_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign map_out      = map_reg;
  assign recording    = (state_reg == RECORD);
  assign assign_pulse = assign_pulse_reg;
  assign assign_key   = assign_key_reg;
  assign assign_note  = assign_note_reg;
  assign done_pulse   = done_pulse_reg;
  assign abort_pulse  = abort_pulse_reg;

endmodule

// File: tb/tb_key_map_recorder.sv
// Directed bench for key_map_recorder with a short debounce window.
module tb_key_map_recorder;

  localparam int DB = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  key_in;
  logic        setting;
  logic [31:0] map_out;
  logic        recording;
  logic        assign_pulse;
  logic [2:0]  assign_key;
  logic [2:0]  assign_note;
  logic        done_pulse;
  logic        abort_pulse;

  key_map_recorder #(
    .NKEYS(8),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .setting     (setting),
    .map_out     (map_out),
    .recording   (recording),
    .assign_pulse(assign_pulse),
    .assign_key  (assign_key),
    .assign_note (assign_note),
    .done_pulse  (done_pulse),
    .abort_pulse (abort_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Strobe logging, sampled on the falling edge away from the active edge.
  int          assign_cnt = 0;
  int          done_cnt   = 0;
  int          abort_cnt  = 0;
  logic [2:0]  ak_log [0:63];
  logic [2:0]  an_log [0:63];
  logic [31:0] done_map;
  logic        done_with_assign;
  logic        done_rec;

  always @(negedge clk) begin
    if (assign_pulse) begin
      ak_log[assign_cnt & 63] <= assign_key;
      an_log[assign_cnt & 63] <= assign_note;
      assign_cnt <= assign_cnt + 1;
      $display("assign key=%0d note=%0d t=%0t", assign_key, assign_note, $time);
    end
    if (done_pulse) begin
      done_cnt         <= done_cnt + 1;
      done_map         <= map_out;
      done_with_assign <= assign_pulse;
      done_rec         <= recording;
      $display("done map=%h t=%0t", map_out, $time);
    end
    if (abort_pulse) begin
      abort_cnt <= abort_cnt + 1;
      $display("abort t=%0t", $time);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    key_in[k] = 1'b1;
    wait_cycles(10);
    key_in[k] = 1'b0;
    wait_cycles(10);
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_d, base_b, first;

    rst     = 1'b1;
    key_in  = '0;
    setting = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    #1;

    // ---- reset state, idle for 100 cycles ----
    check("rst_map", map_out, 32'h01234567);
    check("rst_rec", 32'(recording), 32'd0);
    check("rst_akey", 32'(assign_key), 32'd0);
    check("rst_anote", 32'(assign_note), 32'd0);
    wait_cycles(100);
    check("idle_assign_cnt", assign_cnt, 0);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_abort_cnt", abort_cnt, 0);
    check("idle_map", map_out, 32'h01234567);

    // ---- full reversed recording ----
    base_a  = assign_cnt;
    setting = 1'b1;
    wait_cycles(10);
    check("t2_rec_on", 32'(recording), 32'd1);
    for (int k = 7; k >= 0; k--) press_key(k);
    check("t2_assign_cnt", assign_cnt - base_a, 8);
    for (int i = 0; i < 8; i++) begin
      check("t2_key", 32'(ak_log[base_a + i]), 32'(7 - i));
      check("t2_note", 32'(an_log[base_a + i]), 32'(i));
    end
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_with_assign", 32'(done_with_assign), 32'd1);
    check("t2_done_rec", 32'(done_rec), 32'd0);
    check("t2_done_map", done_map, 32'h76543210);
    check("t2_map", map_out, 32'h76543210);
    check("t2_rec_off", 32'(recording), 32'd0);
    wait_cycles(20);
    check("t2_no_reenter", 32'(recording), 32'd0);
    setting = 1'b0;
    wait_cycles(10);
    check("t2_no_abort", abort_cnt, 0);

    // ---- duplicate press then abort ----
    base_a  = assign_cnt;
    base_b  = abort_cnt;
    base_d  = done_cnt;
    setting = 1'b1;
    wait_cycles(10);
    press_key(3);
    press_key(3);
    check("t3_assign_cnt", assign_cnt - base_a, 1);
    check("t3_key", 32'(ak_log[base_a]), 32'd3);
    check("t3_note", 32'(an_log[base_a]), 32'd0);
    setting = 1'b0;
    wait_cycles(10);
    check("t3_abort_cnt", abort_cnt - base_b, 1);
    check("t3_done_cnt", done_cnt - base_d, 0);
    check("t3_map", map_out, 32'h76543210);
    check("t3_rec", 32'(recording), 32'd0);

    // ---- bouncing key 2 ----
    base_a  = assign_cnt;
    setting = 1'b1;
    wait_cycles(10);
    for (int i = 0; i < 10; i++) begin
      key_in[2] = ~key_in[2];
      wait_cycles(2);
    end
    check("t4_no_early_assign", assign_cnt - base_a, 0);
    key_in[2] = 1'b1;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      wait_cycles(1);
      if (assign_pulse && first == 0) first = i;
    end
    check("t4_latency", first, 7);
    wait_cycles(10);
    check("t4_assign_cnt", assign_cnt - base_a, 1);
    check("t4_key", 32'(ak_log[base_a]), 32'd2);
    check("t4_note", 32'(an_log[base_a]), 32'd0);
    key_in[2] = 1'b0;
    wait_cycles(10);

    // ---- simultaneous keys 1 and 5 ----
    base_a = assign_cnt;
    key_in[1] = 1'b1;
    key_in[5] = 1'b1;
    wait_cycles(10);
    check("t5_sim_cnt", assign_cnt - base_a, 1);
    check("t5_sim_key", 32'(ak_log[base_a]), 32'd1);
    check("t5_sim_note", 32'(an_log[base_a]), 32'd1);
    key_in[1] = 1'b0;
    key_in[5] = 1'b0;
    wait_cycles(10);
    press_key(5);
    check("t5_key5", 32'(ak_log[base_a + 1]), 32'd5);
    check("t5_note5", 32'(an_log[base_a + 1]), 32'd2);
    press_key(1);
    check("t5_dup1_cnt", assign_cnt - base_a, 2);
    press_key(0);
    check("t5_key0", 32'(ak_log[base_a + 2]), 32'd0);
    check("t5_note0", 32'(an_log[base_a + 2]), 32'd3);
    check("t5_rec", 32'(recording), 32'd1);
    check("t5_map_stable", map_out, 32'h76543210);

    // ---- reset mid-recording with setting held ----
    base_d = done_cnt;
    base_b = abort_cnt;
    rst = 1'b1;
    #1;
    check("t6_map_now", map_out, 32'h01234567);
    check("t6_rec_now", 32'(recording), 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(30);
    check("t6_no_restart", 32'(recording), 32'd0);
    check("t6_done_cnt", done_cnt - base_d, 0);
    check("t6_abort_cnt", abort_cnt - base_b, 0);
    setting = 1'b0;
    wait_cycles(10);
    base_a  = assign_cnt;
    setting = 1'b1;
    wait_cycles(10);
    check("t6_restart", 32'(recording), 32'd1);
    press_key(6);
    check("t6_key", 32'(ak_log[base_a]), 32'd6);
    check("t6_note", 32'(an_log[base_a]), 32'd0);
    setting = 1'b0;
    wait_cycles(10);
    check("t6_abort", abort_cnt - base_b, 1);
    check("t6_map_final", map_out, 32'h01234567);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
